// File: rtl/cpu68k_reg_slave_if.sv
// 68000-style asynchronous bus bundle between a bus master and cpu68k_reg_slave.
// The master drives select/strobe/direction/address/write data; the slave returns read data and DTACK.
interface cpu68k_reg_slave_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
);
   logic              cs;
   logic              ds;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] uio_in;
   logic [DATA_W-1:0] uio_out;
   logic [DATA_W-1:0] uio_oe;
   logic              dtack_n;

   modport master (
      output cs, ds, rw, addr, uio_in,
      input  uio_out, uio_oe, dtack_n
   );

   modport slave (
      input  cs, ds, rw, addr, uio_in,
      output uio_out, uio_oe, dtack_n
   );
endinterface

// File: rtl/cpu68k_reg_slave.sv
// 68000-style register slave: select FSM with programmable DTACK wait states and per-register strobes.
// Optional macro CPU68K_BUS_SYNC_EN adds 2-flop synchronizers on cs, ds and rw.
module cpu68k_reg_slave #(
   parameter int                 DATA_W      = 8,
   parameter int                 ADDR_W      = 2,
   parameter int                 WAIT_STATES = 0,
   parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   cpu68k_reg_slave_if.slave                 bus,
   input  logic [(2**ADDR_W)*DATA_W-1:0]     rd_data,
   output logic [(2**ADDR_W)*DATA_W-1:0]     wr_data,
   output logic [(2**ADDR_W)-1:0]            rd_stb,
   output logic [(2**ADDR_W)-1:0]            wr_stb,
   output logic                              busy
);
   localparam int NUM_REGS = 2**ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_HOLD
   } state_t;

   logic sel;
   logic rw_s;

`ifdef CPU68K_BUS_SYNC_EN
   logic [1:0] cs_sync;
   logic [1:0] ds_sync;
   logic [1:0] rw_sync;

   // rw idles high (read) so a glitch during reset never looks like a write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync <= 2'b00;
         ds_sync <= 2'b00;
         rw_sync <= 2'b11;
      end else begin
         cs_sync <= {cs_sync[0], bus.cs};
         ds_sync <= {ds_sync[0], bus.ds};
         rw_sync <= {rw_sync[0], bus.rw};
      end
   end

   assign sel  = cs_sync[1] & ds_sync[1];
   assign rw_s = rw_sync[1];
`else
   assign sel  = bus.cs & bus.ds;
   assign rw_s = bus.rw;
`endif

   state_t                     state, state_d;
   logic [3:0]                 cnt, cnt_d;
   logic [ADDR_W-1:0]          addr_q, addr_d;
   logic                       rw_q, rw_d;
   logic                       dtack_q, dtack_d;
   logic [DATA_W-1:0]          oe_q, oe_d;
   logic [DATA_W-1:0]          out_q, out_d;
   logic [NUM_REGS-1:0]        rd_stb_q, rd_stb_d;
   logic [NUM_REGS-1:0]        wr_stb_q, wr_stb_d;
   logic [NUM_REGS*DATA_W-1:0] wr_q, wr_d;
   logic                       ack;
   logic [ADDR_W-1:0]          ack_addr;
   logic                       ack_rw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         rw_q     <= 1'b1;
         dtack_q  <= 1'b1;
         oe_q     <= '0;
         out_q    <= '0;
         rd_stb_q <= '0;
         wr_stb_q <= '0;
         wr_q     <= {NUM_REGS{RESET_VAL}};
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         addr_q   <= addr_d;
         rw_q     <= rw_d;
         dtack_q  <= dtack_d;
         oe_q     <= oe_d;
         out_q    <= out_d;
         rd_stb_q <= rd_stb_d;
         wr_stb_q <= wr_stb_d;
         wr_q     <= wr_d;
      end
   end

   // With zero wait states the acknowledge uses the live addr/rw on the same edge that latches them
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      addr_d   = addr_q;
      rw_d     = rw_q;
      dtack_d  = dtack_q;
      oe_d     = oe_q;
      out_d    = out_q;
      rd_stb_d = '0;
      wr_stb_d = '0;
      wr_d     = wr_q;
      ack      = 1'b0;
      ack_addr = addr_q;
      ack_rw   = rw_q;

      case (state)
         S_IDLE: begin
            if (sel) begin
               addr_d = bus.addr;
               rw_d   = rw_s;
               cnt_d  = 4'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  ack      = 1'b1;
                  ack_addr = bus.addr;
                  ack_rw   = rw_s;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!sel) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  ack = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (!sel) begin
               dtack_d = 1'b1;
               oe_d    = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (ack) begin
         state_d = S_HOLD;
         dtack_d = 1'b0;
         if (ack_rw) begin
            out_d              = rd_data[int'(ack_addr)*DATA_W +: DATA_W];
            oe_d               = '1;
            rd_stb_d[ack_addr] = 1'b1;
         end else begin
            wr_d[int'(ack_addr)*DATA_W +: DATA_W] = bus.uio_in;
            wr_stb_d[ack_addr]                    = 1'b1;
         end
      end
   end

   assign bus.uio_out = out_q;
   assign bus.uio_oe  = oe_q;
   assign bus.dtack_n = dtack_q;
   assign wr_data     = wr_q;
   assign rd_stb      = rd_stb_q;
   assign wr_stb      = wr_stb_q;
   assign busy        = (state != S_IDLE);
endmodule

// File: tb/tb_cpu68k_reg_slave.sv
// Scoreboard bench for cpu68k_reg_slave: three instances (0, 3 and 4 wait states) share one bus stimulus.
// Each instance has its own transaction-level model queue and an independent monitor.
module tb_cpu68k_reg_slave;
   localparam int DW = 8;
   localparam int AW = 2;
   localparam int NR = 4;
`ifdef CPU68K_BUS_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      logic       rd;
      int         a;
      logic [7:0] d;
      int         low;
      int         start;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cs = 1'b0;
   logic        ds = 1'b0;
   logic        rw = 1'b1;
   logic [1:0]  addr = '0;
   logic [7:0]  uio_in = '0;
   logic [31:0] rd_data = '0;

   int          tests = 0;
   int          fails = 0;
   int          clk_count = 0;

   event        cyc_ev;
   event        done_ev;
   logic        cyc_rd;
   int          cyc_addr;
   logic [7:0]  cyc_wdata;
   int          cyc_hold;
   int          cyc_start;

   always #5 clk = ~clk;

   always @(posedge clk) clk_count++;

   task automatic checkOutput(input string name, input int inst,
                              input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s dut%0d: got %h expected %h", name, inst, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g
      localparam int W = (gi == 0) ? 0 : ((gi == 1) ? 3 : 4);

      cpu68k_reg_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

      logic [31:0] wr_data;
      logic [3:0]  rd_stb;
      logic [3:0]  wr_stb;
      logic        busy;
      exp_t        q[$];
      logic [7:0]  regs [NR];
      logic        prev_dtack = 1'b1;
      int          low = 0;

      assign bus.cs     = cs;
      assign bus.ds     = ds;
      assign bus.rw     = rw;
      assign bus.addr   = addr;
      assign bus.uio_in = uio_in;

      cpu68k_reg_slave #(
         .DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(W), .RESET_VAL(8'h00)
      ) dut (
         .clk(clk), .rst_n(rst_n), .bus(bus),
         .rd_data(rd_data), .wr_data(wr_data),
         .rd_stb(rd_stb), .wr_stb(wr_stb), .busy(busy)
      );

      function automatic logic [31:0] model_wr();
         logic [31:0] m;
         for (int i = 0; i < NR; i++) m[i*8 +: 8] = regs[i];
         return m;
      endfunction

      initial for (int i = 0; i < NR; i++) regs[i] = 8'h00;

      // A bus cycle completes only if select is held for the select edge plus W wait edges
      always @(cyc_ev) begin
         exp_t e;
         if (cyc_hold >= W + 1) begin
            e.rd    = cyc_rd;
            e.a     = cyc_addr;
            e.d     = cyc_rd ? rd_data[cyc_addr*8 +: 8] : cyc_wdata;
            e.low   = cyc_hold - W;
            e.start = cyc_start;
            q.push_back(e);
            if (!cyc_rd) regs[cyc_addr] = cyc_wdata;
         end
      end

      always @(negedge rst_n) begin
         #1;
         checkOutput("rst_dtack_n", gi, 32'(bus.dtack_n), 32'd1);
         checkOutput("rst_uio_oe", gi, 32'(bus.uio_oe), 32'd0);
         checkOutput("rst_uio_out", gi, 32'(bus.uio_out), 32'd0);
         checkOutput("rst_wr_data", gi, wr_data, 32'd0);
         checkOutput("rst_strobes", gi, 32'({rd_stb, wr_stb}), 32'd0);
         checkOutput("rst_busy", gi, 32'(busy), 32'd0);
         q.delete();
         for (int i = 0; i < NR; i++) regs[i] = 8'h00;
      end

      always @(negedge clk) begin
         exp_t        e;
         logic [3:0]  onehot;
         if (!rst_n) begin
            prev_dtack = 1'b1;
            low = 0;
         end else begin
            if (prev_dtack && !bus.dtack_n) begin
               low = 1;
               if (q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL unexpected_dtack dut%0d: dtack_n low with no cycle pending, expected high", gi);
               end else begin
                  e = q[0];
                  onehot = 4'b0001 << e.a;
                  checkOutput("ack_latency", gi, 32'(clk_count - e.start), 32'(1 + W + LAT));
                  if (e.rd) begin
                     checkOutput("read_data", gi, 32'(bus.uio_out), 32'(e.d));
                     checkOutput("read_oe", gi, 32'(bus.uio_oe), 32'hFF);
                     checkOutput("rd_stb", gi, 32'(rd_stb), 32'(onehot));
                     checkOutput("wr_stb_on_read", gi, 32'(wr_stb), 32'd0);
                  end else begin
                     checkOutput("write_reg", gi, 32'(wr_data[e.a*8 +: 8]), 32'(e.d));
                     checkOutput("wr_stb", gi, 32'(wr_stb), 32'(onehot));
                     checkOutput("rd_stb_on_write", gi, 32'(rd_stb), 32'd0);
                     checkOutput("write_oe", gi, 32'(bus.uio_oe), 32'd0);
                  end
                  checkOutput("all_wr_data", gi, wr_data, model_wr());
                  checkOutput("busy_in_hold", gi, 32'(busy), 32'd1);
               end
            end else if (!bus.dtack_n) begin
               low++;
               checkOutput("strobe_single_pulse", gi, 32'({rd_stb, wr_stb}), 32'd0);
               if (q.size() != 0 && q[0].rd) begin
                  checkOutput("read_data_held", gi, 32'({bus.uio_oe, bus.uio_out}), 32'({8'hFF, q[0].d}));
               end
            end else if (!prev_dtack) begin
               if (q.size() != 0) begin
                  checkOutput("dtack_low_cycles", gi, 32'(low), 32'(q[0].low));
                  void'(q.pop_front());
               end
               checkOutput("release_oe", gi, 32'(bus.uio_oe), 32'd0);
               checkOutput("release_busy", gi, 32'(busy), 32'd0);
               checkOutput("release_strobes", gi, 32'({rd_stb, wr_stb}), 32'd0);
            end else begin
               checkOutput("idle_strobes", gi, 32'({rd_stb, wr_stb}), 32'd0);
            end
            prev_dtack = bus.dtack_n;
         end
      end

      always @(done_ev) begin
         checkOutput("pending_at_end", gi, 32'(q.size()), 32'd0);
         checkOutput("final_wr_data", gi, wr_data, model_wr());
      end
   end

   // Holds select for h edges, scrambles addr/rw after they are latched and data after every ack
   task automatic applyStimulus(input logic r, input int a, input logic [7:0] wd,
                                input int h, input int idle);
      cyc_rd    = r;
      cyc_addr  = a;
      cyc_wdata = wd;
      cyc_hold  = h;
      cyc_start = clk_count;
      ->cyc_ev;
      cs     = 1'b1;
      ds     = 1'b1;
      rw     = r;
      addr   = 2'(a);
      uio_in = wd;
      for (int k = 0; k < h; k++) begin
         @(posedge clk);
         #1;
         if (k == LAT) begin
            addr = 2'($urandom);
            rw   = 1'($urandom);
         end
         if (k == 4 + LAT) begin
            uio_in  = 8'($urandom);
            rd_data = $urandom;
         end
      end
      if ($urandom_range(0, 1) == 1) ds = 1'b0;
      else cs = 1'b0;
      repeat (idle) @(posedge clk);
      #1;
   endtask

   initial begin
      #3 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      rd_data = {8'h5A, 8'h96, 8'h3C, 8'hC3};
      applyStimulus(1'b0, 2, 8'hA5, 2, 1);
      rd_data = {8'h5A, 8'h96, 8'h3C, 8'hC3};
      applyStimulus(1'b1, 1, 8'h00, 10, 1);
      applyStimulus(1'b0, 1, 8'h77, 3, 2);
      rd_data = {8'h5A, 8'h96, 8'h3C, 8'hC3};
      applyStimulus(1'b0, 0, 8'h11, 6, 1);
      applyStimulus(1'b1, 0, 8'h00, 6, 1);

      cyc_rd    = 1'b0;
      cyc_addr  = 3;
      cyc_wdata = 8'hE7;
      cyc_hold  = 12;
      cyc_start = clk_count;
      ->cyc_ev;
      cs     = 1'b1;
      ds     = 1'b1;
      rw     = 1'b0;
      addr   = 2'd3;
      uio_in = 8'hE7;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      cs = 1'b0;
      ds = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int n = 0; n < 40; n++) begin
         rd_data = $urandom;
         applyStimulus(1'($urandom), $urandom_range(0, 3), 8'($urandom),
                       $urandom_range(1, 8), $urandom_range(1, 3));
      end

      repeat (3) @(posedge clk);
      #1 ->done_ev;
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
